// File: rtl/mult_hilo_unit.sv
// Shift-add multiplier with HI/LO registers; stalls the PC while running.
// Define MULT_SIGNED_EN to add MULT (signed) support via sign-magnitude.
module mult_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] fin;
  logic [WIDTH-1:0] ld_a;
  logic [WIDTH-1:0] ld_b;
  logic             ld_neg;

`ifdef MULT_SIGNED_EN
  logic neg;

  // Signed requests latch magnitudes; the sign is restored at the end
  always_comb begin
    ld_a   = op_a;
    ld_b   = op_b;
    ld_neg = 1'b0;
    if (is_signed) begin
      ld_a   = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
      ld_b   = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
      ld_neg = op_a[WIDTH-1] ^ op_b[WIDTH-1];
    end
  end

  // Final product, negated when the operand signs differed
  always_comb begin
    fin = neg ? (~step + 1'b1) : step;
  end
`else
  logic unused_is_signed;

  // Unsigned only: operands go straight in
  always_comb begin
    ld_a             = op_a;
    ld_b             = op_b;
    ld_neg           = 1'b0;
    unused_is_signed = is_signed ^ ld_neg;
  end

  // No sign fix-up in the unsigned build
  always_comb begin
    fin = step;
  end
`endif

  // One shift-add iteration: add mcand when LSB set, shift {carry,hi,lo}
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    step = {sum, lo[WIDTH-1:1]};
  end

  // Stall on request in IDLE and throughout RUN; release in DONE
  always_comb begin
    stall = busy | ((state == IDLE) & start);
  end

  // MFHI/MFLO read port
  always_comb begin
    rd_data = rd_sel ? hi : lo;
  end

  // Control FSM with datapath registers and registered busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= ld_a;
            hi    <= '0;
            lo    <= ld_b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef MULT_SIGNED_EN
            neg   <= ld_neg;
`endif
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            {hi, lo} <= fin;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            {hi, lo} <= step;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Bench for mult_hilo_unit: cycle model of stall/busy/done and product.
// Follows MULT_SIGNED_EN the same way the design does.
module tb_mult_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         rd_sel = 1'b0;
  logic [W-1:0] rd_data;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_chk = 0;
  int n_fail = 0;

  int           ph = 0;
  logic [2*W-1:0] pend = '0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mult_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .is_signed(is_signed),
    .op_a(op_a),
    .op_b(op_b),
    .rd_sel(rd_sel),
    .rd_data(rd_data),
    .stall(stall),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] product(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         s
  );
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic [2*W-1:0] ua;
    logic [2*W-1:0] ub;
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    sa = $signed(a);
    sb = $signed(b);
`ifdef MULT_SIGNED_EN
    if (s) return sa * sb;
`else
    if (s && 1'b0) return sa * sb;
`endif
    return ua * ub;
  endfunction

  // Reference: ph=0 idle, 1..W running, W+1 completion cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0;
      exp_hi = '0;
      exp_lo = '0;
    end else if (ph == 0) begin
      if (start) begin
        ph = 1;
        pend = product(op_a, op_b, is_signed);
      end
    end else if (ph <= W) begin
      ph++;
      if (ph == W + 1) {exp_hi, exp_lo} = pend;
    end else begin
      ph = 0;
    end
  end

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    logic run_e;
    run_e = (ph >= 1) && (ph <= W);
    chk("busy", 64'(busy), 64'(run_e));
    chk("done", 64'(done), 64'(ph == W + 1));
    chk("stall", 64'(stall), 64'(run_e || (ph == 0 && start)));
    if (!run_e) begin
      chk("hi", 64'(hi), 64'(exp_hi));
      chk("lo", 64'(lo), 64'(exp_lo));
      chk("rd_data", 64'(rd_data),
          64'(rd_sel ? exp_hi : exp_lo));
    end
  end

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic         s,
                        input int           chg_at,
                        input int           drop_at,
                        input int           rst_at);
    bit got;
    got = 0;
    @(posedge clk);
    #1;
    op_a = a;
    op_b = b;
    is_signed = s;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (i == chg_at) begin
        op_a = '0;
        op_b = '0;
      end
      if (i == drop_at) start = 1'b0;
      if (i == rst_at) begin
        #1;
        rst = 1'b1;
        start = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        for (int j = 0; j < W + 3; j++) begin
          @(negedge clk);
          chk("rst_no_done", 64'(done), 64'd0);
        end
        return;
      end
      if (done) begin
        chk("latency", 64'(i), 64'(W + 1));
        got = 1;
        break;
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    rd_sel = 1'b0;
    #1 chk("reset_mflo", 64'(rd_data), 64'd0);
    rd_sel = 1'b1;
    #1 chk("reset_mfhi", 64'(rd_data), 64'd0);

    run_op(32'd7, 32'd6, 1'b0, 0, 0, 0);
    chk("b_hi", 64'(hi), 64'd0);
    chk("b_lo", 64'(lo), 64'd42);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0, 0);
    chk("max_hi", 64'(hi), 64'hFFFFFFFE);
    chk("max_lo", 64'(lo), 64'h00000001);

    run_op(32'h00010000, 32'h00010000, 1'b0, 0, 0, 10);
    run_op(32'd3, 32'd5, 1'b0, 0, 0, 0);
    rd_sel = 1'b0;
    #1 chk("after_rst_mflo", 64'(rd_data), 64'd15);

    run_op(32'd100, 32'd3, 1'b0, 2, 0, 0);
    chk("chg_lo", 64'(lo), 64'd300);

    run_op(32'd9, 32'd11, 1'b0, 0, 5, 0);
    chk("drop_lo", 64'(lo), 64'd99);

    run_op(32'hFFFFFFFD, 32'd5, 1'b1, 0, 0, 0);
`ifdef MULT_SIGNED_EN
    chk("s_hi", 64'(hi), 64'hFFFFFFFF);
    chk("s_lo", 64'(lo), 64'hFFFFFFF1);
    run_op(32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 0, 0, 0);
    chk("nn_hi", 64'(hi), 64'd0);
    chk("nn_lo", 64'(lo), 64'd16);
`else
    chk("s_hi", 64'(hi), 64'h00000004);
    chk("s_lo", 64'(lo), 64'hFFFFFFF1);
`endif

    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom;
      if (k % 6 == 1) b = '1;
      if (k % 6 == 2) a = 32'h80000000;
      if (k % 6 == 3) b = '0;
      rd_sel = 1'($urandom_range(0, 1));
      run_op(a, b, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, W) : 0,
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, W) : 0,
             0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Sequential shift-add multiplier with architectural HI/LO registers for the single-cycle MIPS core.
- Executes MULTU (and MULT when compiled in) over WIDTH cycles.
- Sits beside the ALU: takes operands from the register-file read ports and stalls the PC while running.
- Drives the writeback mux with HI or LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits and the run phase lasts WIDTH cycles.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  multiply request, decoded from the R-type funct by alu_ctl.
- is_signed  input  1  1 = MULT, 0 = MULTU (only meaningful when the optional feature is present).
- op_a  input  WIDTH  multiplicand (rs).
- op_b  input  WIDTH  multiplier (rt).
- rd_sel  input  1  0 = LO, 1 = HI (MFLO/MFHI).
- rd_data  output  WIDTH  combinational: HI if rd_sel=1, else LO.
- stall  output  1  holds the PC and suppresses RegWrite while high.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.

Behaviour:
- Clock/reset: one clock, clk. Reset is rst, asynchronous and active-high.
- Reset values: state=IDLE; hi=0, lo=0, counter=0, internal multiplicand register=0; busy=0, done=0. stall goes to 0 once start is low.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - stall = start, combinationally.
  - On a clock edge with start=1: load mcand=op_a, hi=0, lo=op_b, counter=0; go to RUN.
- RUN:
  - busy=1, stall=1.
  - Each cycle: sum = {1'b0,hi} + (lo[0] ? {1'b0,mcand} : 0), WIDTH+1 bits.
  - Then {hi,lo} <= {sum, lo[WIDTH-1:1]}, i.e. the 2*WIDTH+1-bit value {carry,hi,lo} shifted right by one.
  - Counter increments; after the WIDTH-th iteration go to DONE.
- DONE:
  - done=1, stall=0, busy=0. The PC advances on this edge.
  - start is ignored here, because the same instruction is still presented. Go to IDLE.
- Latency: the request is accepted on edge k. RUN covers cycles k+1..k+WIDTH. done is high in cycle k+WIDTH+1. Total stall is WIDTH+1 cycles.
- hi/lo hold their value between operations. Intermediate values are visible during RUN; software must not issue MFHI/MFLO while stalled (the PC is frozen anyway).
- Operand changes after acceptance have no effect, because operands are latched.
- Product is exact and unsigned mod 2^(2*WIDTH); there is no overflow or exception.
- Reset mid-RUN: immediate return to IDLE, hi/lo cleared, done never pulses.
- start deasserted mid-RUN: the operation still completes.
- rd_data is purely combinational from the hi/lo registers and is valid in every state.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- With the macro defined, at acceptance when is_signed=1:
  - latch mcand=|op_a|, lo=|op_b|, and neg = op_a[WIDTH-1] ^ op_b[WIDTH-1].
  - On the DONE transition, if neg=1, replace {hi,lo} with its two's-complement negation.
  - Latency is unchanged.
- With the macro undefined: is_signed is ignored and every operation is unsigned; the neg logic is not present.

Test Plan:
- Reset, then MFHI/MFLO: rst pulse → hi=0, lo=0, busy=0, done=0. With start=0, stall=0. rd_sel=0/1 → rd_data=0.
- Basic MULTU: op_a=7, op_b=6, start held high → stall for 33 cycles, done on the 33rd cycle after acceptance. Result hi=0, lo=42. Start is not re-accepted in DONE.
- Max operands: op_a=op_b=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001.
- Mid-run reset: start 32'h00010000*32'h00010000, assert rst at RUN cycle 10 → IDLE immediately, hi=lo=0, no done pulse. A following 3*5 gives lo=15.
- Operand change mid-run: op_a=100, op_b=3 accepted, then op_a/op_b changed to 0 at RUN cycle 2 → lo=300.
- (MULT_SIGNED_EN) is_signed=1:
  - op_a=-3 (32'hFFFFFFFD), op_b=5 → hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
  - -4 × -4 → hi=0, lo=16.
  - Without the macro, the first case gives hi=32'h00000004, lo=32'hFFFFFFF1.
